pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
//  Central sequencer for the 5-stage RISC-V pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards, control transfers resolved in EX and multi-cycle RAM accesses in MEM.
//  Drives the PC/IF_ID load enables, IF_ID clear, ID_EX bubble insertion, a global pipe freeze
//  and the EX operand forwarding selects.
// PARAMETERS
//  REG_AW          5   register address width
//  LOAD_STALL_CYC  1   bubbles inserted per load-use hazard (>=1)
//  MEM_WAIT_MAX    15  max MEM_WAIT cycles before abort/timeout (>=1, counter width $clog2+1)
// PORTS
//  clk              in   1      clock, rising edge
//  Reset            in   1      synchronous, active-low reset
//  ID_rs1, ID_rs2   in   REG_AW source regs of instruction in ID
//  ID_rs1_used, ID_rs2_used in 1 source actually read by ID instruction
//  EX_rd            in   REG_AW dest of instruction in EX
//  EX_RF_Enable     in   1      EX instruction writes RF
//  EX_Load_Instr    in   1      EX instruction is a load
//  EX_ctrl_transfer in   1      taken branch / JAL / JALR resolved in EX
//  MEM_rd, WB_rd    in   REG_AW dest regs in MEM / WB
//  MEM_RF_Enable, WB_RF_Enable in 1 RF write enables in MEM / WB
//  MEM_RAM_Enable   in   1      MEM stage is accessing RAM
//  MEM_ready        in   1      RAM completes access this cycle
//  PC_LE, IF_ID_LE  out  1      load enables for PC and IF_ID
//  IF_ID_Clear      out  1      zero IF_ID (NOP) next edge
//  ID_EX_Bubble     out  1      select all-zero control into ID_EX
//  Pipe_Freeze      out  1      hold ID_EX, EX_MEM, MEM_WB contents
//  fwd_A_sel, fwd_B_sel out 2   00 RF, 01 EX, 10 MEM, 11 WB
//  mem_timeout      out  1      sticky: a RAM access exceeded MEM_WAIT_MAX
//  ctl_state        out  2      debug: current state
// BEHAVIOUR
//  States: RUN=00, LOAD_STALL=01, MEM_WAIT=10. Outputs Mealy (state + current inputs).
//  Reset low (sampled at edge): state=RUN, counters=0, mem_timeout=0; while Reset low outputs
//   forced PC_LE=0, IF_ID_LE=0, IF_ID_Clear=1, ID_EX_Bubble=1, Pipe_Freeze=0, fwd=00.
//   Reset mid-operation aborts any stall/wait immediately; no pending action survives.
//  Default (RUN, no hazard): PC_LE=IF_ID_LE=1, Clear=Bubble=Freeze=0.
//  Priority in RUN: mem-wait > ctrl transfer > load-use.
//  mem-wait: MEM_RAM_Enable & !MEM_ready -> PC_LE=IF_ID_LE=0, Pipe_Freeze=1, ID_EX_Bubble=0;
//   next RUN->MEM_WAIT, wait_cnt=1. MEM_RAM_Enable & MEM_ready same cycle -> no stall.
//  MEM_WAIT: same freeze outputs; MEM_ready=1 -> outputs revert to RUN rules this cycle, next RUN.
//   wait_cnt==MEM_WAIT_MAX & !ready -> mem_timeout<=1, freeze released this cycle, next RUN.
//   EX_ctrl_transfer ignored while frozen; EX held, so it is acted on in the first RUN cycle.
//  ctrl transfer: IF_ID_Clear=1, ID_EX_Bubble=1, PC_LE=1 (target), IF_ID_LE=0; stay RUN.
//   Overrides a simultaneous load-use hazard (ID instruction is wrong path).
//  load-use: EX_Load_Instr & EX_RF_Enable & EX_rd!=0 & ((ID_rs1_used & ID_rs1==EX_rd) |
//   (ID_rs2_used & ID_rs2==EX_rd)) -> PC_LE=IF_ID_LE=0, ID_EX_Bubble=1; if LOAD_STALL_CYC>1
//   next LOAD_STALL with ls_cnt=1, else stay RUN.
//  LOAD_STALL: PC_LE=IF_ID_LE=0, Bubble=1; ls_cnt++; ls_cnt==LOAD_STALL_CYC-1 -> next RUN.
//   mem-wait condition in LOAD_STALL -> freeze rules apply, ls_cnt held, resume after wait.
//  Forwarding (per operand, combinational, independent of state): EX match (rd!=0, RF_Enable,
//   !EX_Load_Instr) -> 01; else MEM match -> 10; else WB match -> 11; else 00. x0 never forwarded.
//  Counters saturate, never wrap; mem_timeout cleared only by reset.
// TESTING
//  Reset low 3 cycles mid MEM_WAIT -> PC_LE=0, Clear=1, Bubble=1, timeout=0; release -> RUN, PC_LE=1.
//  lw x5 in EX, ID add uses rs1=x5 -> one cycle PC_LE=0, Bubble=1; next cycle fwd_A_sel=10.
//  EX_rd=x0 load, ID rs1=x0 -> no stall, fwd_A_sel=00.
//  MEM_RAM_Enable=1, MEM_ready=0 for 4 cycles then 1 -> Freeze=1 for 4 cycles, 5th normal, timeout=0.
//  MEM_ready held 0 with MEM_WAIT_MAX=15 -> freeze ends after 15 cycles, mem_timeout=1 sticky.
//  EX_ctrl_transfer + load-use same cycle -> Clear=1, Bubble=1, PC_LE=1; no LOAD_STALL entry.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for a 5-stage RISC-V pipeline. It detects load-use hazards,
// control transfers resolved in EX and multi-cycle RAM accesses in MEM. It drives
// the pipeline register enables, clear, bubble and freeze controls, and the EX
// operand forwarding selects.
// Outputs are Mealy: they depend on the current state and the current inputs.
// The internal state is visible on ctl_state for debug and checker binding.
module pipeline_hazard_controller #(
   parameter int REG_AW         = 5,
   parameter int LOAD_STALL_CYC = 1,
   parameter int MEM_WAIT_MAX   = 15
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic [REG_AW-1:0] ID_rs1,
   input  logic [REG_AW-1:0] ID_rs2,
   input  logic              ID_rs1_used,
   input  logic              ID_rs2_used,
   input  logic [REG_AW-1:0] EX_rd,
   input  logic              EX_RF_Enable,
   input  logic              EX_Load_Instr,
   input  logic              EX_ctrl_transfer,
   input  logic [REG_AW-1:0] MEM_rd,
   input  logic [REG_AW-1:0] WB_rd,
   input  logic              MEM_RF_Enable,
   input  logic              WB_RF_Enable,
   input  logic              MEM_RAM_Enable,
   input  logic              MEM_ready,
   output logic              PC_LE,
   output logic              IF_ID_LE,
   output logic              IF_ID_Clear,
   output logic              ID_EX_Bubble,
   output logic              Pipe_Freeze,
   output logic [1:0]        fwd_A_sel,
   output logic [1:0]        fwd_B_sel,
   output logic              mem_timeout,
   output logic [1:0]        ctl_state
);

   typedef enum logic [1:0] {
      RUN        = 2'b00,
      LOAD_STALL = 2'b01,
      MEM_WAIT   = 2'b10
   } state_t;

   localparam int WW = $clog2(MEM_WAIT_MAX) + 1;
   localparam int LW = $clog2(LOAD_STALL_CYC) + 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX);
   localparam logic [LW-1:0] LS_LAST   = LW'(LOAD_STALL_CYC - 1);

   state_t          state;
   logic [WW-1:0]   wait_cnt;
   logic [LW-1:0]   ls_cnt;
   // A RAM wait that interrupted a load stall must return to that stall afterwards.
   logic            resume_ls;

   logic mem_wait, load_use, timeout_now, freeze_now, act_ls;

   // Forwarding priority: youngest producer first. A load in EX cannot forward yet.
   // x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] rs,
      input logic [REG_AW-1:0] ex_rd,  input logic ex_en,
      input logic [REG_AW-1:0] mem_rd, input logic mem_en,
      input logic [REG_AW-1:0] wb_rd,  input logic wb_en
   );
      if (ex_en && ex_rd != '0 && ex_rd == rs)        return 2'b01;
      else if (mem_en && mem_rd != '0 && mem_rd == rs) return 2'b10;
      else if (wb_en && wb_rd != '0 && wb_rd == rs)    return 2'b11;
      else                                             return 2'b00;
   endfunction

   // Hazard conditions derived from the current pipeline contents.
   always_comb begin
      mem_wait    = MEM_RAM_Enable & ~MEM_ready;
      load_use    = EX_Load_Instr & EX_RF_Enable & (EX_rd != '0) &
                    ((ID_rs1_used & (ID_rs1 == EX_rd)) | (ID_rs2_used & (ID_rs2 == EX_rd)));
      timeout_now = (state == MEM_WAIT) & mem_wait & (wait_cnt >= WAIT_LAST);
      freeze_now  = mem_wait & ~timeout_now;
      act_ls      = (state == LOAD_STALL) | ((state == MEM_WAIT) & resume_ls);
   end

   // Mealy output decode. Priority: RAM wait, then load stall, then control
   // transfer, then load-use. Reset forces a flushed, non-advancing pipe.
   always_comb begin
      PC_LE        = 1'b1;
      IF_ID_LE     = 1'b1;
      IF_ID_Clear  = 1'b0;
      ID_EX_Bubble = 1'b0;
      Pipe_Freeze  = 1'b0;
      fwd_A_sel    = fwd_sel(ID_rs1, EX_rd, EX_RF_Enable & ~EX_Load_Instr,
                             MEM_rd, MEM_RF_Enable, WB_rd, WB_RF_Enable);
      fwd_B_sel    = fwd_sel(ID_rs2, EX_rd, EX_RF_Enable & ~EX_Load_Instr,
                             MEM_rd, MEM_RF_Enable, WB_rd, WB_RF_Enable);
      if (!Reset) begin
         PC_LE        = 1'b0;
         IF_ID_LE     = 1'b0;
         IF_ID_Clear  = 1'b1;
         ID_EX_Bubble = 1'b1;
         fwd_A_sel    = 2'b00;
         fwd_B_sel    = 2'b00;
      end else if (freeze_now) begin
         PC_LE       = 1'b0;
         IF_ID_LE    = 1'b0;
         Pipe_Freeze = 1'b1;
      end else if (act_ls) begin
         PC_LE        = 1'b0;
         IF_ID_LE     = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else if (EX_ctrl_transfer) begin
         // The instruction in ID is on the wrong path, so any load-use hazard is moot.
         IF_ID_LE     = 1'b0;
         IF_ID_Clear  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (load_use) begin
         PC_LE        = 1'b0;
         IF_ID_LE     = 1'b0;
         ID_EX_Bubble = 1'b1;
      end
   end

   // State, counters and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         ls_cnt      <= '0;
         resume_ls   <= 1'b0;
         mem_timeout <= 1'b0;
      end else if (freeze_now) begin
         if (state != MEM_WAIT) begin
            state     <= MEM_WAIT;
            wait_cnt  <= WW'(1);
            resume_ls <= (state == LOAD_STALL);
         end else if (wait_cnt < WAIT_LAST) begin
            wait_cnt <= wait_cnt + WW'(1);
         end
      end else begin
         if (timeout_now) mem_timeout <= 1'b1;
         wait_cnt  <= '0;
         resume_ls <= 1'b0;
         if (act_ls) begin
            if (ls_cnt >= LS_LAST) begin
               state  <= RUN;
               ls_cnt <= '0;
            end else begin
               state  <= LOAD_STALL;
               ls_cnt <= ls_cnt + LW'(1);
            end
         end else if (!EX_ctrl_transfer && load_use && LOAD_STALL_CYC > 1) begin
            state  <= LOAD_STALL;
            ls_cnt <= LW'(1);
         end else begin
            state <= RUN;
         end
      end
   end

   assign ctl_state = state;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller with its default parameters.
// Each cycle, the bench pushes the expected output vector onto exp_q. At the
// falling edge it pops the vector and compares it against the DUT outputs.
// Vector layout:
//   {PC_LE, IF_ID_LE, IF_ID_Clear, ID_EX_Bubble, Pipe_Freeze,
//    fwd_A_sel, fwd_B_sel, mem_timeout, ctl_state}
module tb_pipeline_hazard_controller;

   localparam int W = 12;

   logic       clk = 1'b0;
   logic       Reset;
   logic [4:0] ID_rs1, ID_rs2, EX_rd, MEM_rd, WB_rd;
   logic       ID_rs1_used, ID_rs2_used, EX_RF_Enable, EX_Load_Instr, EX_ctrl_transfer;
   logic       MEM_RF_Enable, WB_RF_Enable, MEM_RAM_Enable, MEM_ready;
   logic       PC_LE, IF_ID_LE, IF_ID_Clear, ID_EX_Bubble, Pipe_Freeze, mem_timeout;
   logic [1:0] fwd_A_sel, fwd_B_sel, ctl_state;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;

   // Clock generation.
   always #5 clk = ~clk;

   pipeline_hazard_controller dut (
      .clk(clk), .Reset(Reset),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
      .EX_rd(EX_rd), .EX_RF_Enable(EX_RF_Enable), .EX_Load_Instr(EX_Load_Instr),
      .EX_ctrl_transfer(EX_ctrl_transfer),
      .MEM_rd(MEM_rd), .WB_rd(WB_rd), .MEM_RF_Enable(MEM_RF_Enable), .WB_RF_Enable(WB_RF_Enable),
      .MEM_RAM_Enable(MEM_RAM_Enable), .MEM_ready(MEM_ready),
      .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_Clear(IF_ID_Clear), .ID_EX_Bubble(ID_EX_Bubble),
      .Pipe_Freeze(Pipe_Freeze), .fwd_A_sel(fwd_A_sel), .fwd_B_sel(fwd_B_sel),
      .mem_timeout(mem_timeout), .ctl_state(ctl_state)
   );

   function automatic logic [W-1:0] exp_v(input logic pc, input logic ifid, input logic clr,
                                          input logic bub, input logic frz,
                                          input logic [1:0] fa, input logic [1:0] fb,
                                          input logic to, input logic [1:0] st);
      return {pc, ifid, clr, bub, frz, fa, fb, to, st};
   endfunction

   // Reference forwarding select, taken from the operand-forwarding rules.
   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (EX_RF_Enable && !EX_Load_Instr && EX_rd != 5'd0 && EX_rd == rs) return 2'b01;
      if (MEM_RF_Enable && MEM_rd != 5'd0 && MEM_rd == rs)                return 2'b10;
      if (WB_RF_Enable && WB_rd != 5'd0 && WB_rd == rs)                   return 2'b11;
      return 2'b00;
   endfunction

   task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // One clock cycle: queue the expectation, compare at the falling edge, then
   // advance past the next rising edge.
   task automatic step(input string tag, input logic [W-1:0] e);
      exp_q.push_back(e);
      @(negedge clk);
      check_eq(tag, {PC_LE, IF_ID_LE, IF_ID_Clear, ID_EX_Bubble, Pipe_Freeze,
                     fwd_A_sel, fwd_B_sel, mem_timeout, ctl_state}, exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Reset = 1'b1;
      ID_rs1 = '0; ID_rs2 = '0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0;
      EX_rd = '0; EX_RF_Enable = 1'b0; EX_Load_Instr = 1'b0; EX_ctrl_transfer = 1'b0;
      MEM_rd = '0; WB_rd = '0; MEM_RF_Enable = 1'b0; WB_RF_Enable = 1'b0;
      MEM_RAM_Enable = 1'b0; MEM_ready = 1'b0;
   endtask

   task automatic load_use_x5();
      EX_rd = 5'd5; EX_Load_Instr = 1'b1; EX_RF_Enable = 1'b1;
      ID_rs1 = 5'd5; ID_rs1_used = 1'b1;
   endtask

   // Stimulus sequence.
   initial begin
      logic [W-1:0] RST, NORM, FRZ0, FRZ1, CTRL;
      RST  = exp_v(0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00);
      NORM = exp_v(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00);
      FRZ0 = exp_v(0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00);
      FRZ1 = exp_v(0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b10);
      CTRL = exp_v(1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b00);

      idle();
      Reset = 1'b0;
      step("reset0", RST);
      step("reset1", RST);
      idle();
      step("run_after_reset", NORM);

      // Load-use on rs1: one stall cycle, then the load is forwarded from MEM.
      load_use_x5();
      step("load_use_stall", exp_v(0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 2'b00));
      idle();
      ID_rs1 = 5'd5; ID_rs1_used = 1'b1; MEM_rd = 5'd5; MEM_RF_Enable = 1'b1;
      step("load_use_fwd_mem", exp_v(1, 1, 0, 0, 0, 2'b10, 2'b00, 0, 2'b00));

      // A load to x0 never creates a hazard.
      idle();
      EX_Load_Instr = 1'b1; EX_RF_Enable = 1'b1; ID_rs1_used = 1'b1;
      step("x0_load_no_stall", NORM);

      // Random forwarding patterns, with no hazard possible since no source is used.
      for (int i = 0; i < 20; i++) begin
         idle();
         ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
         EX_rd = 5'($urandom_range(0, 3));  MEM_rd = 5'($urandom_range(0, 3));
         WB_rd = 5'($urandom_range(0, 3));
         EX_RF_Enable = 1'($urandom_range(0, 1)); EX_Load_Instr = 1'($urandom_range(0, 1));
         MEM_RF_Enable = 1'($urandom_range(0, 1)); WB_RF_Enable = 1'($urandom_range(0, 1));
         step("fwd_random", exp_v(1, 1, 0, 0, 0, exp_fwd(ID_rs1), exp_fwd(ID_rs2), 0, 2'b00));
      end

      // RAM wait of 4 cycles, then the access completes.
      idle();
      MEM_RAM_Enable = 1'b1;
      step("memwait_1", FRZ0);
      step("memwait_2", FRZ1);
      step("memwait_3", FRZ1);
      step("memwait_4", FRZ1);
      MEM_ready = 1'b1;
      step("memwait_ready", exp_v(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10));
      idle();
      step("memwait_back_run", NORM);

      // A control transfer overrides a simultaneous load-use hazard.
      load_use_x5();
      EX_ctrl_transfer = 1'b1;
      step("ctrl_over_load_use", CTRL);
      idle();
      step("ctrl_no_load_stall", NORM);

      // A control transfer is ignored while frozen and acted on once the wait ends.
      MEM_RAM_Enable = 1'b1; EX_ctrl_transfer = 1'b1;
      step("ctrl_frozen_1", FRZ0);
      step("ctrl_frozen_2", FRZ1);
      MEM_ready = 1'b1;
      step("ctrl_after_wait", exp_v(1, 0, 1, 1, 0, 2'b00, 2'b00, 0, 2'b10));
      idle();
      step("ctrl_wait_run", NORM);

      // RAM never ready: the freeze lasts 15 cycles, then releases and the timeout sticks.
      MEM_RAM_Enable = 1'b1;
      step("timeout_first", FRZ0);
      for (int i = 0; i < 14; i++) step("timeout_frozen", FRZ1);
      step("timeout_release", exp_v(1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b10));
      idle();
      step("timeout_sticky_1", exp_v(1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00));
      step("timeout_sticky_2", exp_v(1, 1, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00));

      // Reset in the middle of a RAM wait aborts it and clears the timeout flag.
      MEM_RAM_Enable = 1'b1;
      step("rst_mid_wait_a", exp_v(0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 2'b00));
      step("rst_mid_wait_b", exp_v(0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 2'b10));
      Reset = 1'b0; EX_rd = 5'd3; EX_RF_Enable = 1'b1; ID_rs1 = 5'd3;
      step("rst_hold_1", exp_v(0, 0, 1, 1, 0, 2'b00, 2'b00, 1, 2'b10));
      step("rst_hold_2", RST);
      step("rst_hold_3", RST);
      idle();
      step("rst_release_run", NORM);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
